// File: rtl/hex_display_ctrl.sv
// hex_display_ctrl: latches a GPIO word and drives NUM_DIGITS registered seven-segment digits (ports: clk, rst async active-low, load/data_in/mode/digit_en capture, seg_out {g..a} per digit, shown_val after rotation, blink_phase)
module hex_display_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int BLINK_DIV = 25_000_000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [1:0]              mode,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [7*NUM_DIGITS-1:0] seg_out,
  output logic [4*NUM_DIGITS-1:0] shown_val,
  output logic                    blink_phase
);
  localparam int cw = $clog2(BLINK_DIV);
  localparam logic [6:0] pol = SEG_ACTIVE_LOW ? 7'h00 : 7'h7F;
  localparam logic [6:0] blank = 7'h7F ^ pol;
  localparam logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [4*NUM_DIGITS-1:0] val_q;
  logic [1:0]              mode_q;
  logic [NUM_DIGITS-1:0]   en_q;
  logic [cw-1:0]           cnt;
  logic                    load_d;
  logic                    wrap;
  logic                    tick;
  logic                    lz_run;
  logic [4*NUM_DIGITS-1:0] rot;
  logic [7*NUM_DIGITS-1:0] seg_d;
  assign wrap = cnt == cw'(BLINK_DIV - 1);
  assign tick = wrap && !load;
  assign rot = (shown_val << 4) | (shown_val >> (4 * NUM_DIGITS - 4));
  // lz_run stays high while every digit from the top down to i is zero
  always_comb begin
    lz_run = 1'b1;
    seg_d = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      lz_run = lz_run && shown_val[4*i+:4] == 4'd0;
      seg_d[7*i+:7] = (!en_q[i] || (mode_q == 2'b10 && blink_phase) || (mode_q == 2'b01 && i != 0 && lz_run))
                      ? blank : glyph[shown_val[4*i+:4]] ^ pol;
    end
  end
  // shown_val follows val_q one cycle after a load, so a pending load overrides any rotation
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      val_q <= '0;
      mode_q <= 2'b00;
      en_q <= '1;
      cnt <= '0;
      blink_phase <= 1'b0;
      load_d <= 1'b0;
      shown_val <= '0;
      seg_out <= {NUM_DIGITS{blank}};
    end else begin
      load_d <= load;
      if (load) begin
        val_q <= data_in;
        mode_q <= mode;
        en_q <= digit_en;
        cnt <= '0;
        blink_phase <= 1'b0;
      end else begin
        cnt <= wrap ? '0 : cnt + 1'b1;
        blink_phase <= blink_phase ^ wrap;
      end
      shown_val <= load_d ? val_q : (tick && mode_q == 2'b11) ? rot : shown_val;
      seg_out <= seg_d;
    end
  end
endmodule

// File: tb/tb_hex_display_ctrl.sv
// tb_hex_display_ctrl: table, hand-written and randomized checks of hex_display_ctrl against a closed-form model
module tb_hex_display_ctrl;
  localparam int N = 8;
  localparam int DIV = 4;
  localparam logic [6:0] GL [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                     7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  typedef struct {
    logic [31:0] d;
    logic [1:0]  m;
    logic [7:0]  e;
    logic [55:0] seg;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic load = 1'b0;
  logic [31:0] data_in = '0;
  logic [1:0] mode = '0;
  logic [7:0] digit_en = '0;
  logic [55:0] seg_out;
  logic [31:0] shown_val;
  logic blink_phase;
  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] m_val;
  logic [1:0] m_mode;
  logic [7:0] m_en;
  int k;
  vec_t tbl [7];
  always #5 clk = ~clk;
  hex_display_ctrl #(.NUM_DIGITS(N), .BLINK_DIV(DIV), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .load(load), .data_in(data_in), .mode(mode), .digit_en(digit_en),
    .seg_out(seg_out), .shown_val(shown_val), .blink_phase(blink_phase)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (k=%0d)", name, act, want, k);
    end
  endtask
  function automatic logic [31:0] exp_shown(input int t);
    logic [31:0] v;
    v = m_val;
    if (m_mode == 2'd3) repeat ((t / DIV) % N) v = v * 16 + v / 32'h1000_0000;
    return v;
  endfunction
  function automatic logic [55:0] exp_seg(input int t);
    logic [31:0] s;
    logic ph;
    logic b;
    logic [55:0] r;
    s = exp_shown(t);
    ph = ((t / DIV) % 2) == 1;
    r = '0;
    for (int i = 0; i < N; i++) begin
      b = !m_en[i] || (m_mode == 2'd2 && ph) || (m_mode == 2'd1 && i > 0 && (s >> (4 * i)) == 0);
      r[7*i+:7] = b ? 7'h7F : GL[s[4*i+:4]];
    end
    return r;
  endfunction
  task automatic cyc();
    @(posedge clk);
    #1;
    if (load) begin
      m_val = data_in;
      m_mode = mode;
      m_en = digit_en;
      k = 0;
    end else k++;
    chk("phase", 64'(blink_phase), 64'((k / DIV) % 2));
    if (k >= 1) chk("shown", 64'(shown_val), 64'(exp_shown(k)));
    if (k >= 2) chk("seg", 64'(seg_out), 64'(exp_seg(k - 1)));
  endtask
  task automatic ld(input logic [31:0] d, input logic [1:0] m, input logic [7:0] e);
    load = 1'b1;
    data_in = d;
    mode = m;
    digit_en = e;
    cyc();
    load = 1'b0;
    data_in = $urandom;
    mode = 2'($urandom);
    digit_en = 8'($urandom);
  endtask
  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    chk("rst_seg", 64'(seg_out), 64'({8{7'h7F}}));
    chk("rst_shown", 64'(shown_val), 64'd0);
    chk("rst_phase", 64'(blink_phase), 64'd0);
    load = 1'b0;
    m_val = '0;
    m_mode = 2'd0;
    m_en = 8'hFF;
    k = 0;
    @(negedge clk);
    rst = 1'b1;
  endtask
  initial begin
    tbl[0] = '{32'h0123_ABCD, 2'd0, 8'hFF, {7'h40, 7'h79, 7'h24, 7'h30, 7'h08, 7'h03, 7'h46, 7'h21}};
    tbl[1] = '{32'h0000_00A0, 2'd1, 8'hFF, {{6{7'h7F}}, 7'h08, 7'h40}};
    tbl[2] = '{32'h0000_0000, 2'd1, 8'hFF, {{7{7'h7F}}, 7'h40}};
    tbl[3] = '{32'h8888_8888, 2'd0, 8'h0F, {{4{7'h7F}}, {4{7'h00}}}};
    tbl[4] = '{32'h0010_0000, 2'd1, 8'hFF, {7'h7F, 7'h7F, 7'h79, {5{7'h40}}}};
    tbl[5] = '{32'h8888_8888, 2'd2, 8'hFF, {8{7'h00}}};
    tbl[6] = '{32'hFEDC_9876, 2'd0, 8'hAA, {7'h0E, 7'h7F, 7'h21, 7'h7F, 7'h10, 7'h7F, 7'h78, 7'h7F}};
    @(posedge clk);
    #1;
    do_reset();
    repeat (3) cyc();
    for (int i = 0; i < 7; i++) begin
      ld(tbl[i].d, tbl[i].m, tbl[i].e);
      repeat (2) cyc();
      chk($sformatf("tbl%0d_seg", i), 64'(seg_out), 64'(tbl[i].seg));
      chk($sformatf("tbl%0d_shown", i), 64'(shown_val), 64'(tbl[i].d));
    end
    ld(32'h1234_5678, 2'd3, 8'hFF);
    repeat (2) cyc();
    do_reset();
    repeat (3) cyc();
    ld(32'h8888_8888, 2'd2, 8'hFF);
    for (int j = 1; j <= 16; j++) begin
      cyc();
      if (j % 4 == 2) chk("blink_seg", 64'(seg_out), ((j / 4) % 2) ? 64'({8{7'h7F}}) : 64'({8{7'h00}}));
    end
    ld(32'h1234_5678, 2'd3, 8'hFF);
    repeat (4) cyc();
    chk("rot4", 64'(shown_val), 64'h2345_6781);
    repeat (28) cyc();
    chk("rot32", 64'(shown_val), 64'h1234_5678);
    ld(32'h1234_5678, 2'd3, 8'hFF);
    repeat (3) cyc();
    ld(32'h1234_5678, 2'd0, 8'h0F);
    chk("edge_shown", 64'(shown_val), 64'h1234_5678);
    chk("edge_phase", 64'(blink_phase), 64'd0);
    repeat (2) cyc();
    chk("edge_seg_hi", 64'(seg_out[55:28]), 64'({4{7'h7F}}));
    repeat (2) cyc();
    chk("edge_tick", 64'(blink_phase), 64'd1);
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      if ($urandom_range(7) == 0) ld($urandom, 2'($urandom), 8'($urandom));
      else cyc();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
